// File: rtl/fetch_unit.sv
// fetch_unit: Y86 byte-serial fetch stage and predicted-PC register.
// Define FETCH_PREDICT_TAKEN_EN to predict conditional jumps taken.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        F_stall_i,
  input  logic [3:0]  M_icode_i,
  input  logic        M_Cnd_i,
  input  logic [31:0] M_valA_i,
  input  logic [3:0]  W_icode_i,
  input  logic [31:0] W_valM_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [7:0]  imem_rdata_i,
  input  logic        imem_err_i,
  output logic [3:0]  f_icode_o,
  output logic [3:0]  f_ifun_o,
  output logic [3:0]  f_rA_o,
  output logic [3:0]  f_rB_o,
  output logic [3:0]  f_dstE_o,
  output logic [3:0]  f_dstM_o,
  output logic [31:0] f_valC_o,
  output logic [31:0] f_valP_o,
  output logic [2:0]  f_stat_o,
  output logic        f_valid_o,
  output logic        f_busy_o
);

`ifdef FETCH_PREDICT_TAKEN_EN
  localparam logic JXX_TAKEN = 1'b1;
`else
  localparam logic JXX_TAKEN = 1'b0;
`endif

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVL = 4'h2;
  localparam logic [3:0] I_IRMOVL = 4'h3;
  localparam logic [3:0] I_RMMOVL = 4'h4;
  localparam logic [3:0] I_MRMOVL = 4'h5;
  localparam logic [3:0] I_OPL    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHL  = 4'hA;
  localparam logic [3:0] I_POPL   = 4'hB;

  localparam logic [3:0] RESP  = 4'h4;
  localparam logic [3:0] RNONE = 4'hF;

  localparam logic [2:0] ST_AOK = 3'd1;
  localparam logic [2:0] ST_HLT = 3'd2;
  localparam logic [2:0] ST_ADR = 3'd3;
  localparam logic [2:0] ST_INS = 3'd4;

  typedef enum logic [2:0] {
    S_OP,
    S_REG,
    S_CONST,
    S_OUT,
    S_HALT
  } state_t;

  typedef struct packed {
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [3:0]  dste;
    logic [3:0]  dstm;
    logic [31:0] valc;
    logic [31:0] valp;
    logic [2:0]  stat;
    logic        valid;
  } fout_t;

  function automatic logic [2:0] ilen(input logic [3:0] ic);
    logic [2:0] n;
    case (ic)
      I_RRMOVL, I_OPL, I_PUSHL, I_POPL: n = 3'd2;
      I_JXX, I_CALL:                    n = 3'd5;
      I_IRMOVL, I_RMMOVL, I_MRMOVL:     n = 3'd6;
      default:                          n = 3'd1;
    endcase
    return n;
  endfunction

  function automatic logic has_reg(input logic [3:0] ic);
    return ic inside {I_RRMOVL, I_IRMOVL, I_RMMOVL, I_MRMOVL,
                      I_OPL, I_PUSHL, I_POPL};
  endfunction

  function automatic logic has_const(input logic [3:0] ic);
    return ic inside {I_IRMOVL, I_RMMOVL, I_MRMOVL, I_JXX, I_CALL};
  endfunction

  // Non-pipeline fields keep their last value across bubbles.
  function automatic fout_t bubble(input fout_t f);
    fout_t b;
    b       = f;
    b.icode = I_NOP;
    b.ifun  = 4'h0;
    b.dste  = RNONE;
    b.dstm  = RNONE;
    b.stat  = ST_AOK;
    b.valid = 1'b0;
    return b;
  endfunction

  state_t      state;
  state_t      nxt_asm;
  logic [31:0] pc;
  logic [1:0]  cnt;
  logic [3:0]  ic_q;
  logic [3:0]  fn_q;
  logic [3:0]  ra_q;
  logic [3:0]  rb_q;
  logic [31:0] valc_q;
  fout_t       fq;
  fout_t       fd;

  logic [3:0]  ic_n;
  logic [3:0]  fn_n;
  logic [3:0]  ra_n;
  logic [3:0]  rb_n;
  logic [31:0] valc_n;
  logic [2:0]  idx;
  logic        done;
  logic        mispredict;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] pred_pc;

  assign mispredict  = (M_icode_i == I_JXX) && (M_Cnd_i != JXX_TAKEN);
  assign redirect    = mispredict || (W_icode_i == I_RET);
  assign redirect_pc = mispredict ? M_valA_i : W_valM_i;

  assign pred_pc =
    (fq.icode == I_CALL || (JXX_TAKEN && fq.icode == I_JXX))
      ? fq.valc : fq.valp;

  assign imem_req_o  = state inside {S_OP, S_REG, S_CONST};
  assign imem_addr_o = pc + {29'd0, idx};

  always_comb begin
    idx = 3'd0;
    unique case (state)
      S_REG:   idx = 3'd1;
      S_CONST: idx = (has_reg(ic_q) ? 3'd2 : 3'd1) + {1'b0, cnt};
      default: idx = 3'd0;
    endcase
  end

  always_comb begin
    ic_n   = ic_q;
    fn_n   = fn_q;
    ra_n   = ra_q;
    rb_n   = rb_q;
    valc_n = valc_q;
    unique case (state)
      S_OP: begin
        ic_n   = imem_rdata_i[7:4];
        fn_n   = imem_rdata_i[3:0];
        ra_n   = RNONE;
        rb_n   = RNONE;
        valc_n = '0;
      end
      S_REG: begin
        ra_n = imem_rdata_i[7:4];
        rb_n = imem_rdata_i[3:0];
      end
      S_CONST: valc_n[{cnt, 3'b000} +: 8] = imem_rdata_i;
      default: ;
    endcase
  end

  always_comb begin
    done = 1'b0;
    unique case (state)
      S_OP:    done = (ic_n > I_POPL) || (ilen(ic_n) == 3'd1);
      S_REG:   done = !has_const(ic_q);
      S_CONST: done = (cnt == 2'd3);
      default: done = 1'b0;
    endcase
    nxt_asm = (state == S_OP && has_reg(ic_n)) ? S_REG : S_CONST;
  end

  // Completed-instruction image, latched on the final (or faulting) ack.
  always_comb begin
    fd.icode = imem_err_i ? I_NOP : ic_n;
    fd.ifun  = imem_err_i ? 4'h0 : fn_n;
    fd.ra    = ra_n;
    fd.rb    = rb_n;
    fd.valc  = valc_n;
    fd.valp  = pc + {29'd0, ilen(fd.icode)};
    fd.valid = 1'b1;
    if (imem_err_i)
      fd.stat = ST_ADR;
    else if (ic_n > I_POPL)
      fd.stat = ST_INS;
    else if (ic_n == I_HALT)
      fd.stat = ST_HLT;
    else
      fd.stat = ST_AOK;
    fd.dste = RNONE;
    unique case (1'b1)
      fd.icode inside {I_RRMOVL, I_IRMOVL, I_OPL}:
        fd.dste = fd.rb;
      fd.icode inside {I_PUSHL, I_POPL, I_CALL, I_RET}:
        fd.dste = RESP;
      default:
        fd.dste = RNONE;
    endcase
    fd.dstm = (fd.icode inside {I_MRMOVL, I_POPL}) ? fd.ra : RNONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_OP;
      pc       <= RESET_PC;
      cnt      <= 2'd0;
      ic_q     <= I_NOP;
      fn_q     <= 4'h0;
      ra_q     <= RNONE;
      rb_q     <= RNONE;
      valc_q   <= '0;
      fq.icode <= I_NOP;
      fq.ifun  <= 4'h0;
      fq.ra    <= RNONE;
      fq.rb    <= RNONE;
      fq.dste  <= RNONE;
      fq.dstm  <= RNONE;
      fq.valc  <= '0;
      fq.valp  <= '0;
      fq.stat  <= ST_AOK;
      fq.valid <= 1'b0;
      f_busy_o <= 1'b0;
    end else if (redirect) begin
      state    <= S_OP;
      pc       <= redirect_pc;
      cnt      <= 2'd0;
      fq       <= bubble(fq);
      f_busy_o <= 1'b1;
    end else begin
      unique case (state)
        S_OP, S_REG, S_CONST: begin
          f_busy_o <= 1'b1;
          if (imem_ack_i) begin
            ic_q   <= ic_n;
            fn_q   <= fn_n;
            ra_q   <= ra_n;
            rb_q   <= rb_n;
            valc_q <= valc_n;
            if (imem_err_i || done) begin
              state    <= S_OUT;
              fq       <= fd;
              f_busy_o <= 1'b0;
            end else if (state == S_CONST) begin
              cnt <= cnt + 2'd1;
            end else begin
              state <= nxt_asm;
              cnt   <= 2'd0;
            end
          end
        end
        S_OUT: begin
          if (!F_stall_i) begin
            fq <= bubble(fq);
            if (fq.stat != ST_AOK) begin
              state    <= S_HALT;
              f_busy_o <= 1'b0;
            end else begin
              state    <= S_OP;
              pc       <= pred_pc;
              f_busy_o <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign f_icode_o = fq.icode;
  assign f_ifun_o  = fq.ifun;
  assign f_rA_o    = fq.ra;
  assign f_rB_o    = fq.rb;
  assign f_dstE_o  = fq.dste;
  assign f_dstM_o  = fq.dstm;
  assign f_valC_o  = fq.valc;
  assign f_valP_o  = fq.valp;
  assign f_stat_o  = fq.stat;
  assign f_valid_o = fq.valid;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit against a zero-wait
// byte memory with hand-computed expectations.
module tb_fetch_unit;

`ifdef FETCH_PREDICT_TAKEN_EN
  localparam bit TAKEN = 1'b1;
`else
  localparam bit TAKEN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        F_stall;
  logic [3:0]  M_icode;
  logic        M_Cnd;
  logic [31:0] M_valA;
  logic [3:0]  W_icode;
  logic [31:0] W_valM;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [7:0]  imem_rdata;
  logic        imem_err;
  logic [3:0]  f_icode;
  logic [3:0]  f_ifun;
  logic [3:0]  f_rA;
  logic [3:0]  f_rB;
  logic [3:0]  f_dstE;
  logic [3:0]  f_dstM;
  logic [31:0] f_valC;
  logic [31:0] f_valP;
  logic [2:0]  f_stat;
  logic        f_valid;
  logic        f_busy;

  logic [7:0]  mem [0:1023];
  logic        err_en;
  logic [31:0] err_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign imem_ack   = imem_req;
  assign imem_rdata = mem[imem_addr[9:0]];
  assign imem_err   = imem_req && err_en && (imem_addr == err_addr);

  fetch_unit #(.RESET_PC(32'h0)) dut (
    .clk          (clk),
    .rst          (rst),
    .F_stall_i    (F_stall),
    .M_icode_i    (M_icode),
    .M_Cnd_i      (M_Cnd),
    .M_valA_i     (M_valA),
    .W_icode_i    (W_icode),
    .W_valM_i     (W_valM),
    .imem_req_o   (imem_req),
    .imem_addr_o  (imem_addr),
    .imem_ack_i   (imem_ack),
    .imem_rdata_i (imem_rdata),
    .imem_err_i   (imem_err),
    .f_icode_o    (f_icode),
    .f_ifun_o     (f_ifun),
    .f_rA_o       (f_rA),
    .f_rB_o       (f_rB),
    .f_dstE_o     (f_dstE),
    .f_dstM_o     (f_dstM),
    .f_valC_o     (f_valC),
    .f_valP_o     (f_valP),
    .f_stat_o     (f_stat),
    .f_valid_o    (f_valid),
    .f_busy_o     (f_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst      = 1'b1;
    F_stall  = 1'b0;
    M_icode  = 4'h1;
    M_Cnd    = 1'b0;
    M_valA   = '0;
    W_icode  = 4'h1;
    W_valM   = '0;
    err_en   = 1'b0;
    err_addr = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h10;
    mem[0]     = 8'h10;
    mem[1]     = 8'h00;
    mem[10'h100] = 8'h30;
    mem[10'h101] = 8'hF3;
    mem[10'h102] = 8'h78;
    mem[10'h103] = 8'h56;
    mem[10'h104] = 8'h34;
    mem[10'h105] = 8'h12;
    mem[10'h200] = 8'h70;
    mem[10'h201] = 8'h00;
    mem[10'h202] = 8'h04;
    mem[10'h203] = 8'h00;
    mem[10'h204] = 8'h00;
    mem[10'h040] = 8'hC0;
    mem[10'h300] = 8'h50;
    mem[10'h301] = 8'h12;
    mem[10'h302] = 8'h08;
    mem[10'h303] = 8'h00;
    mem[10'h304] = 8'h00;
    mem[10'h305] = 8'h00;

    tick();
    tick();
    chk("rst_valid", f_valid, 0);
    chk("rst_icode", f_icode, 4'h1);
    chk("rst_rA", f_rA, 4'hF);
    chk("rst_rB", f_rB, 4'hF);
    chk("rst_dstE", f_dstE, 4'hF);
    chk("rst_valC", f_valC, 0);
    chk("rst_valP", f_valP, 0);
    chk("rst_stat", f_stat, 1);
    chk("rst_busy", f_busy, 0);

    rst = 1'b0;
    chk("first_req", imem_req, 1);
    chk("first_addr", imem_addr, 0);
    tick();
    chk("nop_valid", f_valid, 1);
    chk("nop_icode", f_icode, 4'h1);
    chk("nop_valP", f_valP, 1);
    chk("nop_busy", f_busy, 0);
    tick();
    chk("halt_fetch_addr", imem_addr, 1);
    chk("halt_fetch_busy", f_busy, 1);
    chk("halt_fetch_valid", f_valid, 0);
    tick();
    chk("halt_valid", f_valid, 1);
    chk("halt_icode", f_icode, 4'h0);
    chk("halt_stat", f_stat, 2);
    chk("halt_valP", f_valP, 2);
    tick();
    chk("halted_req", imem_req, 0);
    chk("halted_valid", f_valid, 0);
    chk("halted_busy", f_busy, 0);
    tick();
    chk("halted_req2", imem_req, 0);

    F_stall = 1'b1;
    W_icode = 4'h9;
    W_valM  = 32'h100;
    tick();
    W_icode = 4'h1;
    F_stall = 1'b0;
    chk("ret_req", imem_req, 1);
    chk("ret_addr", imem_addr, 32'h100);
    chk("ret_valid", f_valid, 0);

    for (int i = 0; i < 5; i++) tick();
    chk("ir_pend_valid", f_valid, 0);
    chk("ir_pend_addr", imem_addr, 32'h105);
    tick();
    chk("ir_valid", f_valid, 1);
    chk("ir_icode", f_icode, 4'h3);
    chk("ir_rA", f_rA, 4'hF);
    chk("ir_rB", f_rB, 4'h3);
    chk("ir_dstE", f_dstE, 4'h3);
    chk("ir_dstM", f_dstM, 4'hF);
    chk("ir_valC", f_valC, 32'h12345678);
    chk("ir_valP", f_valP, 32'h106);
    chk("ir_busy", f_busy, 0);

    F_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_valid", f_valid, 1);
      chk("stall_valC", f_valC, 32'h12345678);
      chk("stall_valP", f_valP, 32'h106);
      chk("stall_req", imem_req, 0);
    end
    F_stall = 1'b0;
    tick();
    chk("ir_next_addr", imem_addr, 32'h106);
    chk("ir_next_valid", f_valid, 0);

    mem[0] = 8'h80;
    mem[1] = 8'h00;
    mem[2] = 8'h02;
    mem[3] = 8'h00;
    mem[4] = 8'h00;
    W_icode = 4'h9;
    W_valM  = 32'h0;
    tick();
    W_icode = 4'h1;
    chk("call_addr", imem_addr, 0);
    for (int i = 0; i < 5; i++) tick();
    chk("call_valid", f_valid, 1);
    chk("call_icode", f_icode, 4'h8);
    chk("call_dstE", f_dstE, 4'h4);
    chk("call_valC", f_valC, 32'h200);
    chk("call_valP", f_valP, 32'h5);
    tick();
    chk("call_next_req", imem_req, 1);
    chk("call_next_addr", imem_addr, 32'h200);

    tick();
    tick();
    tick();
    chk("mp_addr", imem_addr, 32'h203);
    M_icode = 4'h7;
    M_Cnd   = TAKEN ? 1'b0 : 1'b1;
    M_valA  = 32'h40;
    tick();
    M_icode = 4'h1;
    chk("mp_valid", f_valid, 0);
    chk("mp_req", imem_req, 1);
    chk("mp_addr_new", imem_addr, 32'h40);

    tick();
    chk("ins_valid", f_valid, 1);
    chk("ins_stat", f_stat, 4);
    chk("ins_valP", f_valP, 32'h41);
    tick();
    chk("ins_halt_req", imem_req, 0);
    chk("ins_halt_valid", f_valid, 0);

    W_icode  = 4'h9;
    W_valM   = 32'h300;
    err_en   = 1'b1;
    err_addr = 32'h302;
    tick();
    W_icode = 4'h1;
    chk("adr_addr", imem_addr, 32'h300);
    tick();
    tick();
    chk("adr_pend_addr", imem_addr, 32'h302);
    chk("adr_pend_busy", f_busy, 1);
    chk("adr_pend_valid", f_valid, 0);
    tick();
    err_en = 1'b0;
    chk("adr_valid", f_valid, 1);
    chk("adr_stat", f_stat, 3);
    chk("adr_busy", f_busy, 0);
    tick();
    chk("adr_halt_req", imem_req, 0);

    W_icode = 4'h9;
    W_valM  = 32'h200;
    tick();
    W_icode = 4'h1;
    for (int i = 0; i < 5; i++) tick();
    chk("jxx_valid", f_valid, 1);
    chk("jxx_icode", f_icode, 4'h7);
    chk("jxx_valC", f_valC, 32'h400);
    chk("jxx_valP", f_valP, 32'h205);
    chk("jxx_dstE", f_dstE, 4'hF);
    tick();
    chk("jxx_pred", imem_addr, TAKEN ? 32'h400 : 32'h205);

    rst = 1'b1;
    tick();
    chk("rstm_valid", f_valid, 0);
    chk("rstm_valC", f_valC, 0);
    chk("rstm_valP", f_valP, 0);
    chk("rstm_busy", f_busy, 0);
    rst = 1'b0;
    chk("rstm_addr", imem_addr, 0);
    chk("rstm_req", imem_req, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Y86 fetch stage with its F (predicted-PC) register. It sits directly upstream of the decode pipeline register and drives every `f_*` input that register latches. It fetches instructions byte-serially over a req/ack instruction-memory port, assembles icode/ifun, rA/rB and valC, and computes valP, dstE/dstM and the predicted next PC. While an instruction is still being assembled it emits NOP bubbles, so the decode register can latch it every unstalled cycle.

## Interface
- `RESET_PC`, default 32'h0: PC loaded at reset.
- `clk`  in  1: clock.
- `rst`  in  1: reset, synchronous, active-high.
- `F_stall_i`  in  1: hold the completed instruction; do not advance the PC.
- `M_icode_i`  in  4: icode in M stage.
- `M_Cnd_i`  in  1: branch condition in M stage.
- `M_valA_i`  in  32: correct target for a mispredicted jump.
- `W_icode_i`  in  4: icode in W stage.
- `W_valM_i`  in  32: return address.
- `imem_req_o`  out  1: byte read request.
- `imem_addr_o`  out  32: byte address.
- `imem_ack_i`  in  1: data valid this cycle. May be asserted combinationally in the same cycle as the request.
- `imem_rdata_i`  in  8: returned byte.
- `imem_err_i`  in  1: address error, qualified by ack.
- `f_icode_o`, `f_ifun_o`, `f_rA_o`, `f_rB_o`, `f_dstE_o`, `f_dstM_o`  out  4 each: decoded fields.
- `f_valC_o`, `f_valP_o`  out  32: constant and fall-through PC.
- `f_stat_o`  out  3: status. AOK=1, HLT=2, ADR=3, INS=4.
- `f_valid_o`  out  1: outputs carry a real instruction.
- `f_busy_o`  out  1: assembly in progress. The hazard unit uses it.

## Operation
- Length by icode:
  - 1 byte: HALT(0), NOP(1), RET(9).
  - 2 bytes: RRMOVL(2), OPL(6), PUSHL(A), POPL(B).
  - 5 bytes: JXX(7), CALL(8), with no register byte.
  - 6 bytes: IRMOVL(3), RMMOVL(4), MRMOVL(5).
- icode > B sets stat INS with length 1.
- valC is assembled little-endian from 4 bytes.
- valP = PC + length, modulo 2^32.
- dstE:
  - rB for icode 2, 3, 6.
  - RESP(4) for icode A, B, 8, 9.
  - otherwise RNONE(F).
- dstM = rA for icode 5 and B; otherwise RNONE.
- Predicted PC: valC for CALL and (see Configuration) JXX; otherwise valP.
- FSM states:
  - S_OP: fetch byte 0.
  - S_REG: fetch the register byte.
  - S_CONST: fetch 4 constant bytes, with a 2-bit counter.
  - S_OUT: present the instruction.
  - S_HALT: stopped.
- Transitions:
  - S_OP goes to S_REG, S_CONST or S_OUT according to the decoded length.
  - S_REG goes to S_CONST or S_OUT.
  - S_CONST goes to S_OUT after counter = 3.
  - S_OUT goes to S_OP when F_stall_i = 0, and loads PC ← predPC.
  - S_OUT goes to S_HALT instead when stat ≠ AOK.
- A state advances only on a cycle with `imem_ack_i` = 1.
- `imem_req_o` = 1 in S_OP, S_REG and S_CONST; `imem_addr_o` = PC + byte index.
- An ack with `imem_err_i` ends assembly immediately: stat = ADR, go to S_OUT.
- Redirect selection, in priority order:
  1. Mispredict (M_icode=JXX with the condition below) → M_valA_i.
  2. W_icode=RET → W_valM_i.
- A redirect is evaluated every cycle in every state, and wins over F_stall_i and S_HALT.
- On redirect: the partial instruction is discarded, including any ack arriving that cycle. PC ← target, state ← S_OP, and outputs are a bubble on the next cycle.
- Bubble outputs: icode=NOP, ifun=0, dstE=dstM=RNONE, stat=AOK, valid=0. All other fields hold their previous value.

## Timing
- Reset:
  - PC=RESET_PC, state=S_OP.
  - Outputs = bubble, with rA=rB=F and valC=valP=0.
  - `f_busy_o`=0.
  - `imem_req_o` is asserted from the first cycle after reset deassertion.
- All `f_*` outputs are registered.
- Valid is asserted the cycle after the final byte ack. It stays high for exactly one cycle, or for as long as F_stall_i holds in S_OUT.
- Minimum latency with ack on every cycle:
  - 1-byte instruction: valid 1 cycle after the first request, i.e. 2 cycles per instruction.
  - 6-byte instruction: 7 cycles per instruction.
- `f_busy_o` = 1 in S_OP/S_REG/S_CONST once the first request is issued, and 0 in S_OUT and S_HALT.
- `rst` mid-assembly returns to the reset state on the next edge; an ack in that cycle is ignored.

## Configuration
- `FETCH_PREDICT_TAKEN_EN` defined:
  - JXX is predicted taken (predPC = valC).
  - Mispredict = M_icode=JXX and M_Cnd=0.
- `FETCH_PREDICT_TAKEN_EN` undefined:
  - JXX is predicted not-taken (predPC = valP).
  - Mispredict = M_icode=JXX and M_Cnd=1.
  - M_valA_i is still used as the target.
- CALL always predicts valC.

## Test plan
- Reset, then bytes 10 00 at 0 (zero-wait memory) → NOP valid cycle 2 with valP=1; HALT next with stat=HLT, valP=2, then S_HALT with req=0.
- irmovl: bytes 30 F3 78 56 34 12 at 0x100 → valid once with icode=3, rB=3, dstE=3, valC=0x12345678, valP=0x106, next imem_addr=0x106.
- call: 80 00 02 00 00 at 0 → dstE=4 and next fetch at 0x200.
- Mispredict: in the cycle of the 3rd constant byte ack, drive M_icode=7 with the mispredict condition and M_valA=0x40 → ack dropped, no valid, next req at addr 0x40.
- RET redirect while S_HALT and F_stall_i=1 → leaves S_HALT and fetches at W_valM.
- Error and invalid bytes:
  - Byte C0 → stat=INS, valid, then halt.
  - imem_err on byte 2 of a 6-byte instruction → stat=ADR, valid, then halt.
  - F_stall_i held 3 cycles in S_OUT → outputs stable and PC unchanged.
